// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle: the word, decimal points and blanking control from the
// display-source mux, plus the anode/segment/DP pins and the frame pulse.
interface seven_seg_scan_driver_if;
  logic [15:0] in_value;
  logic [3:0]  decimal_point;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  // Source side: supplies the word, observes the pins.
  modport master (
    output in_value, decimal_point, blank_lz,
    input  an, seg, dp, frame_start
  );

  // Driver side: consumes the word, drives the pins.
  modport slave (
    input  in_value, decimal_point, blank_lz,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode scan driver. Snapshots the display word once per
// frame, scans the digits with a REFRESH_DIV-cycle dwell, hex-decodes each
// nibble and optionally blanks leading zeros. All outputs are active-low.

// One digit position: hex decode and DP for a single nibble of the shadow word.
// A blanked digit drives every segment and its DP off.
module seven_seg_scan_digit (
  input  logic [3:0] nib,
  input  logic       dp_bit,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp_n
);
  // Hex decode, segment order {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    seg = 7'h7F;
    if (!blank) begin
      case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        4'hF: seg = 7'b0001110;
      endcase
    end
  end

  assign dp_n = blank | ~dp_bit;
endmodule

module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  seven_seg_scan_driver_if.slave bus
);
  localparam int NUM_DIGITS = 4;
  localparam int CW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

  logic [CW-1:0] cnt;
  logic          tick;
  digit_t        digit_sel, digit_nxt;
  logic          snap;

  // Shadow copy of the inputs; only changes on the frame boundary so a digit
  // never shows a half-updated word.
  logic [NUM_DIGITS-1:0][3:0] sh_value;
  logic [NUM_DIGITS-1:0]      sh_dp;
  logic                       sh_blz;
  // Set by the first snapshot; keeps the display dark until there is
  // something real to show.
  logic                       armed;

  logic [NUM_DIGITS:1]        zero_run;
  logic [NUM_DIGITS-1:0]      slot_blank;
  logic [NUM_DIGITS-1:0][6:0] slot_seg;
  logic [NUM_DIGITS-1:0]      slot_dp;

  logic [3:0] an_r;
  logic [6:0] seg_r;
  logic       dp_r;
  logic       frame_r;

  assign tick = (cnt == CNT_LAST);

  // Per-digit dwell prescaler.
  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Digit scan state register; resets to the last digit so the first tick
  // wraps to digit 0 and takes the first snapshot.
  always_ff @(posedge clk) begin
    if (reset) digit_sel <= DIG3;
    else       digit_sel <= digit_nxt;
  end

  // Next digit on each tick; leaving digit 3 marks the frame boundary.
  always_comb begin
    digit_nxt = digit_sel;
    snap      = 1'b0;
    if (tick) begin
      case (digit_sel)
        DIG0: digit_nxt = DIG1;
        DIG1: digit_nxt = DIG2;
        DIG2: digit_nxt = DIG3;
        DIG3: begin
          digit_nxt = DIG0;
          snap      = 1'b1;
        end
      endcase
    end
  end

  // Frame snapshot of word, DP vector and blanking mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blz   <= 1'b0;
      armed    <= 1'b0;
    end else if (snap) begin
      sh_value <= bus.in_value;
      sh_dp    <= bus.decimal_point;
      sh_blz   <= bus.blank_lz;
      armed    <= 1'b1;
    end
  end

  // One-cycle pulse following each snapshot edge.
  always_ff @(posedge clk) begin
    if (reset) frame_r <= 1'b0;
    else       frame_r <= snap;
  end

  // zero_run[i]: nibbles i..3 are zero and no DP is lit on digits i..3.
  // A lit DP on a higher digit keeps the zeros below it visible.
  assign zero_run[NUM_DIGITS] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      // The rightmost digit always shows, even for an all-zero word.
      assign slot_blank[i] = 1'b0;
    end else begin : g_msd
      assign zero_run[i]   = zero_run[i+1] & (sh_value[i] == 4'd0) & ~sh_dp[i];
      assign slot_blank[i] = sh_blz & zero_run[i];
    end

    seven_seg_scan_digit u_digit (
      .nib    (sh_value[i]),
      .dp_bit (sh_dp[i]),
      .blank  (slot_blank[i]),
      .seg    (slot_seg[i]),
      .dp_n   (slot_dp[i])
    );
  end

  // Registered pin drive for the selected digit; dark in reset, before the
  // first snapshot and for blanked digits.
  always_ff @(posedge clk) begin
    if (reset || !armed) begin
      an_r  <= 4'b1111;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= slot_blank[digit_sel] ? 4'b1111 : ~(4'b0001 << digit_sel);
      seg_r <= slot_seg[digit_sel];
      dp_r  <= slot_dp[digit_sel];
    end
  end

  assign bus.an          = an_r;
  assign bus.seg         = seg_r;
  assign bus.dp          = dp_r;
  assign bus.frame_start = frame_r;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV = 4: a frame
// table of expected anode/segment/DP patterns, each frame optionally loading
// new inputs part-way through, plus reset start-up and mid-frame reset runs.
module tb_seven_seg_scan_driver;
  localparam int R = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                         SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110,
                         SF = 7'b0001110, DK = 7'h7F;
  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011,
                         A3 = 4'b0111, AX = 4'b1111;

  // Expected display for one frame (index = digit), plus inputs to load at
  // the first cycle of digit apply_slot (4 = load nothing).
  typedef struct {
    string                name;
    logic [3:0][3:0]      an;
    logic [3:0][6:0]      seg;
    logic [3:0]           dpo;
    int                   apply_slot;
    logic [15:0]          nv;
    logic [3:0]           ndp;
    logic                 nblz;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  frame_t frames [13];

  always #5 clk = ~clk;

  seven_seg_scan_driver_if bus();

  seven_seg_scan_driver #(.REFRESH_DIV(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es,
                       input logic ed, input logic ef);
    checks++;
    if (bus.an !== ea || bus.seg !== es || bus.dp !== ed || bus.frame_start !== ef) begin
      failures++;
      $display("FAIL %s t=%0t got an=%b seg=%b dp=%b fs=%b expected an=%b seg=%b dp=%b fs=%b",
               name, $time, bus.an, bus.seg, bus.dp, bus.frame_start, ea, es, ed, ef);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    frames[0]  = '{"scan_f1", {A3,A2,A1,A0}, {S1,S2,S3,S4}, 4'b1111, 4, 16'h0000, 4'b0000, 1'b0};
    frames[1]  = '{"scan_f2", {A3,A2,A1,A0}, {S1,S2,S3,S4}, 4'b1111, 4, 16'h0000, 4'b0000, 1'b0};
    // New word arrives while digit 1 is lit; this frame must not tear.
    frames[2]  = '{"snap_hold", {A3,A2,A1,A0}, {S1,S2,S3,S4}, 4'b1111, 1, 16'hABCD, 4'b0000, 1'b0};
    frames[3]  = '{"snap_new", {A3,A2,A1,A0}, {SA,SB,SC,SD}, 4'b1111, 0, 16'h0005, 4'b0000, 1'b1};
    frames[4]  = '{"blank_5", {AX,AX,AX,A0}, {DK,DK,DK,S5}, 4'b1111, 0, 16'h0005, 4'b0010, 1'b1};
    frames[5]  = '{"blank_dp1", {AX,AX,A1,A0}, {DK,DK,S0,S5}, 4'b1101, 0, 16'h8888, 4'b1000, 1'b0};
    frames[6]  = '{"dp_map", {A3,A2,A1,A0}, {S8,S8,S8,S8}, 4'b0111, 0, 16'h3210, 4'b0000, 1'b0};
    frames[7]  = '{"hex_3210", {A3,A2,A1,A0}, {S3,S2,S1,S0}, 4'b1111, 0, 16'h7654, 4'b0000, 1'b0};
    frames[8]  = '{"hex_7654", {A3,A2,A1,A0}, {S7,S6,S5,S4}, 4'b1111, 0, 16'hBA98, 4'b0000, 1'b0};
    frames[9]  = '{"hex_ba98", {A3,A2,A1,A0}, {SB,SA,S9,S8}, 4'b1111, 0, 16'hFEDC, 4'b0000, 1'b0};
    frames[10] = '{"hex_fedc", {A3,A2,A1,A0}, {SF,SE,SD,SC}, 4'b1111, 0, 16'h0000, 4'b0000, 1'b1};
    // All-zero word: digit 0 still shows.
    frames[11] = '{"blank_all0", {AX,AX,AX,A0}, {DK,DK,DK,S0}, 4'b1111, 0, 16'h0100, 4'b0000, 1'b1};
    // Only the zeros above the first non-zero nibble go dark.
    frames[12] = '{"blank_0100", {AX,A2,A1,A0}, {DK,S1,S0,S0}, 4'b1111, 4, 16'h0000, 4'b0000, 1'b0};

    reset             = 1'b1;
    bus.in_value      = 16'h1234;
    bus.decimal_point = 4'b0000;
    bus.blank_lz      = 1'b0;

    // Five edges in reset; the last one is edge 0.
    @(negedge clk);
    repeat (5) next_cycle();
    check("reset_dark", AX, DK, 1'b1, 1'b0);
    reset = 1'b0;
    for (int c = 1; c <= R; c++) begin
      next_cycle();
      check("startup", AX, DK, 1'b1, c == R);
    end

    for (int f = 0; f < 13; f++) begin
      for (int s = 0; s < 4; s++) begin
        for (int h = 0; h < R; h++) begin
          next_cycle();
          check(frames[f].name, frames[f].an[s], frames[f].seg[s], frames[f].dpo[s],
                (s == 3) && (h == R - 1));
          if (h == 0 && s == frames[f].apply_slot) begin
            bus.in_value      = frames[f].nv;
            bus.decimal_point = frames[f].ndp;
            bus.blank_lz      = frames[f].nblz;
          end
        end
      end
    end

    // Mid-frame reset: run into digit 2 of the next frame, then pulse reset.
    for (int s = 0; s < 2; s++) begin
      for (int h = 0; h < R; h++) begin
        next_cycle();
        check("pre_reset", frames[12].an[s], frames[12].seg[s], frames[12].dpo[s], 1'b0);
      end
    end
    next_cycle();
    check("pre_reset_d2", A2, S1, 1'b1, 1'b0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("mid_reset_dark", AX, DK, 1'b1, 1'b0);
    for (int k = 1; k <= R; k++) begin
      next_cycle();
      check("mid_restart", AX, DK, 1'b1, k == R);
    end
    next_cycle();
    check("mid_dig0", A0, S0, 1'b1, 1'b0);
    for (int h = 1; h < R; h++) begin
      next_cycle();
      check("mid_dig0_hold", A0, S0, 1'b1, 1'b0);
    end
    next_cycle();
    check("mid_dig1", A1, S0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Consumes the 16-bit display word and 4-bit decimal-point vector produced by the display-source mux and drives a 4-digit, common-anode, time-multiplexed seven-segment display. It snapshots the word once per refresh frame, scans the digits with a programmable per-digit dwell, hex-decodes each nibble, and optionally blanks leading zeros. It sits between the display-source mux and the board's anode, segment and DP pins.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit is displayed; legal range ≥ 2.
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_value  input  16  display word; nibble i → digit i (digit 0 = rightmost, bits [3:0]).
- decimal_point  input  4  bit i = 1 → DP lit on digit i.
- blank_lz  input  1  1 = blank leading zeros.
- an  output  4  anode enables, active-low; an[i] = digit i.
- seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- frame_start  output  1  one-cycle pulse when a new snapshot is taken.

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1, then wraps to 0. tick = (cnt == REFRESH_DIV-1).
- digit_sel (2 bits) advances on each tick: 0→1→2→3→0 (wrap).
- Snapshot: on a tick with digit_sel == 3, latch in_value, decimal_point and blank_lz into shadow registers. Input changes at any other time have no effect until the next snapshot, so the display never tears.
- frame_start is registered and high for exactly the one cycle following the snapshot edge.
- Blanking rule for digit i (i ≥ 1): blank when shadow blank_lz = 1, shadow_value[15:4i] == 0, and shadow_dp[3:i] == 0.
  - Digit 0 is never blanked.
  - A blanked digit drives an[i] = 1, seg = 7'h7F and dp = 1.
- Hex decode, full 0–F: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- Exactly one an bit is low at any time, except during reset, before the first snapshot, and for blanked digits.
- State reset values:
  - cnt = 0, digit_sel = 3 (so the first tick selects digit 0 and takes a snapshot).
  - shadow registers = 0.
  - frame_start = 0; an = 4'b1111, seg = 7'h7F, dp = 1 (display dark).

## Timing
- an, seg and dp are registered from digit_sel and the shadow registers. They reflect a new digit_sel one clock after it updates.
- Reset deasserted at edge 0:
  - cnt reaches REFRESH_DIV-1 in cycle REFRESH_DIV-1.
  - At edge REFRESH_DIV: digit_sel ← 0, snapshot taken, frame_start ← 1.
  - At edge REFRESH_DIV+1: an/seg/dp show digit 0 and frame_start ← 0.
- Each digit is held for exactly REFRESH_DIV cycles. A full frame is 4·REFRESH_DIV cycles, so frame_start repeats with that period.
- Reset asserted mid-frame: at the next edge all state returns to reset values (display dark) and the sequence restarts exactly as above. No partial frame is completed.
- Snapshot and input change in the same cycle: the value present at the snapshot edge is captured.

## Test plan
- Reset: hold reset 5 cycles, then release with REFRESH_DIV = 4 → an = 1111, seg = 7F, dp = 1, frame_start = 0 through cycle 3; frame_start = 1 in cycle 4 only.
- Scan: REFRESH_DIV = 4, in_value = 0x1234, decimal_point = 0000, blank_lz = 0 → each (an, seg) pair held 4 cycles, in this order:
  - an = 1110, seg = 0011001
  - an = 1101, seg = 0110000
  - an = 1011, seg = 0100100
  - an = 0111, seg = 1111001
  - then repeats, with dp = 1 throughout and frame_start every 16 cycles over 3 frames.
- Snapshot: change in_value 0x1234 → 0xABCD while digit 1 is displayed → remainder of the frame still shows 2, 1; the next frame shows d = 0100001, C, b, A.
- Blanking: in_value = 0x0005, blank_lz = 1, dp = 0000 → digits 3..1 show an = 1111; digit 0 shows seg = 0010010. Then set dp = 0010 → digit 1 shows seg = 1000000 with dp = 0, digits 3..2 blank.
- DP mapping: in_value = 0x8888, dp = 1000, blank_lz = 0 → dp = 0 only while an = 0111.
- Mid-frame reset: assert reset for 1 cycle while digit 2 is active → the next cycle is dark, and digit 0 reappears with frame_start exactly REFRESH_DIV+1 cycles after reset deasserts.
